// File: rtl/tmnt_sysio.sv
`default_nettype none
// ============================================================================
// Module   : tmnt_sysio
// Brief    : TMNT 68000-side system I/O (inputs, coin counters, sound
//            mailbox, vblank IRQ, watchdog). Watchdog built when
//            SYSIO_WATCHDOG_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tmnt_sysio #(
    parameter int NPLAYERS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int COIN_PULSE  = 2400000,
    parameter int WDOG_CYCLES = 4800000
) (
    input  logic                  clk_24M,
    input  logic                  nRES,
    input  logic                  cs_n,
    input  logic                  rw,
    input  logic [2:0]            addr,
    input  logic [7:0]            din,
    output logic [7:0]            dout,
    input  logic [8*NPLAYERS-1:0] plyr_in,
    input  logic [NPLAYERS-1:0]   coin_in,
    input  logic [NPLAYERS-1:0]   service_in,
    input  logic [19:0]           dip_in,
    input  logic                  vblank,
    input  logic                  snd_ack,
    output logic [7:0]            snd_code,
    output logic                  snd_irq,
    output logic                  int_n,
    output logic [1:0]            coin_counter,
    output logic                  rmrd,
    output logic                  sndon,
    output logic [1:0]            pri,
    output logic                  wdog_reset_n
);

    localparam int c_SYNC_W = 10*NPLAYERS + 22;
    localparam logic [c_SYNC_W-1:0] c_SYNC_RST = {2'b00, {(c_SYNC_W-2){1'b1}}};
    localparam int c_TW = $clog2(COIN_PULSE + 1);
    localparam logic [c_TW-1:0] c_PULSE_LAST = c_TW'(COIN_PULSE - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_HIGH = 2'd1;
    localparam logic [1:0] c_LOW  = 2'd2;

    // All asynchronous pins share one synchroniser chain.
    logic [c_SYNC_W-1:0] w_async;
    logic [c_SYNC_W-1:0] r_sync [SYNC_STAGES];
    logic [c_SYNC_W-1:0] w_sync;

    assign w_async = {snd_ack, vblank, dip_in, service_in, coin_in, plyr_in};
    assign w_sync  = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= c_SYNC_RST;
        end else begin
            r_sync[0] <= w_async;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    logic [8*NPLAYERS-1:0] w_plyr_s;
    logic [NPLAYERS-1:0]   w_coin_s;
    logic [NPLAYERS-1:0]   w_serv_s;
    logic [19:0]           w_dip_s;
    logic                  w_vb_s;
    logic                  w_ack_s;
    logic [31:0]           w_plyr32;
    logic [3:0]            w_coin4;
    logic [3:0]            w_serv4;

    assign w_plyr_s = w_sync[8*NPLAYERS-1:0];
    assign w_coin_s = w_sync[9*NPLAYERS-1:8*NPLAYERS];
    assign w_serv_s = w_sync[10*NPLAYERS-1:9*NPLAYERS];
    assign w_dip_s  = w_sync[10*NPLAYERS+19:10*NPLAYERS];
    assign w_vb_s   = w_sync[10*NPLAYERS+20];
    assign w_ack_s  = w_sync[10*NPLAYERS+21];

    // Absent players read as released (all ones).
    always_comb begin
        w_plyr32 = '1;
        w_coin4  = '1;
        w_serv4  = '1;
        w_plyr32[8*NPLAYERS-1:0] = w_plyr_s;
        w_coin4[NPLAYERS-1:0]    = w_coin_s;
        w_serv4[NPLAYERS-1:0]    = w_serv_s;
    end

    always_comb begin
        dout = 8'h00;
        if (!cs_n && rw) begin
            case (addr)
                3'd0:    dout = {w_serv4, w_coin4};
                3'd1:    dout = w_plyr32[7:0];
                3'd2:    dout = w_plyr32[15:8];
                3'd3:    dout = w_plyr32[23:16];
                3'd4:    dout = w_plyr32[31:24];
                3'd5:    dout = w_dip_s[7:0];
                3'd6:    dout = w_dip_s[15:8];
                default: dout = {4'hF, w_dip_s[19:16]};
            endcase
        end
    end

    logic r_cs_n_d;
    logic w_wr;
    logic w_wr_ctl;
    logic w_wr_snd;
    logic w_wr_pri;
    logic w_wr_iack;

    assign w_wr      = !cs_n && r_cs_n_d && !rw;
    assign w_wr_ctl  = w_wr && (addr == 3'd0);
    assign w_wr_snd  = w_wr && (addr == 3'd1);
    assign w_wr_pri  = w_wr && (addr == 3'd3);
    assign w_wr_iack = w_wr && (addr == 3'd4);

    logic       r_sndon, r_int16en, r_rmrd;
    logic [1:0] r_pri;
    logic [7:0] r_snd_code;
    logic       r_snd_irq, r_int_n;
    logic       r_vb_d, r_vb_rise, r_ack_d, r_ack_rise;

    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            r_cs_n_d   <= 1'b1;
            r_sndon    <= 1'b0;
            r_int16en  <= 1'b0;
            r_rmrd     <= 1'b0;
            r_pri      <= 2'b00;
            r_snd_code <= 8'h00;
            r_snd_irq  <= 1'b0;
            r_int_n    <= 1'b1;
            r_vb_d     <= 1'b0;
            r_vb_rise  <= 1'b0;
            r_ack_d    <= 1'b0;
            r_ack_rise <= 1'b0;
        end else begin
            r_cs_n_d   <= cs_n;
            r_vb_d     <= w_vb_s;
            r_vb_rise  <= w_vb_s && !r_vb_d;
            r_ack_d    <= w_ack_s;
            r_ack_rise <= w_ack_s && !r_ack_d;
            if (w_wr_ctl) begin
                r_sndon   <= din[3];
                r_int16en <= din[5];
                r_rmrd    <= din[7];
            end
            if (w_wr_pri) r_pri <= din[3:2];
            // A new vblank edge beats any clear in the same clock.
            if (r_vb_rise && r_int16en)
                r_int_n <= 1'b0;
            else if (w_wr_iack || (w_wr_ctl && !din[5]))
                r_int_n <= 1'b1;
            if (w_wr_snd) begin
                r_snd_code <= din;
                r_snd_irq  <= 1'b1;
            end else if (r_ack_rise) begin
                r_snd_irq  <= 1'b0;
            end
        end
    end

    assign sndon    = r_sndon;
    assign rmrd     = r_rmrd;
    assign pri      = r_pri;
    assign snd_code = r_snd_code;
    assign snd_irq  = r_snd_irq;
    assign int_n    = r_int_n;

    genvar gc;
    generate
        for (gc = 0; gc < 2; gc++) begin : g_coin
            logic [3:0]      r_cnt;
            logic [1:0]      r_state;
            logic [c_TW-1:0] r_timer;
            logic            r_pulse;
            logic            w_inc;
            logic            w_take;

            assign w_inc  = w_wr_ctl && din[gc];
            assign w_take = (r_state == c_IDLE) && (r_cnt != 4'd0);

            always_ff @(posedge clk_24M or negedge nRES) begin
                if (!nRES) begin
                    r_cnt   <= 4'd0;
                    r_state <= c_IDLE;
                    r_timer <= '0;
                    r_pulse <= 1'b0;
                end else begin
                    if (w_inc && !w_take && (r_cnt != 4'hF))
                        r_cnt <= r_cnt + 4'd1;
                    else if (w_take && !w_inc)
                        r_cnt <= r_cnt - 4'd1;
                    case (r_state)
                        c_IDLE: begin
                            if (w_take) begin
                                r_state <= c_HIGH;
                                r_timer <= '0;
                                r_pulse <= 1'b1;
                            end
                        end
                        c_HIGH: begin
                            if (r_timer == c_PULSE_LAST) begin
                                r_state <= c_LOW;
                                r_timer <= '0;
                                r_pulse <= 1'b0;
                            end else begin
                                r_timer <= r_timer + 1'b1;
                            end
                        end
                        c_LOW: begin
                            if (r_timer == c_PULSE_LAST) begin
                                r_state <= c_IDLE;
                                r_timer <= '0;
                            end else begin
                                r_timer <= r_timer + 1'b1;
                            end
                        end
                        default: begin
                            r_state <= c_IDLE;
                            r_pulse <= 1'b0;
                        end
                    endcase
                end
            end

            assign coin_counter[gc] = r_pulse;
        end
    endgenerate

`ifdef SYSIO_WATCHDOG_EN
    localparam int c_WW = $clog2(WDOG_CYCLES + 1);

    logic            w_wr_kick;
    logic [c_WW-1:0] r_wdog_cnt;
    logic [3:0]      r_fire_cnt;
    logic            r_wdog_n;

    assign w_wr_kick = w_wr && (addr == 3'd2);

    // While the reset request is active the counter holds; kicks are ignored.
    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            r_wdog_cnt <= '0;
            r_fire_cnt <= 4'd0;
            r_wdog_n   <= 1'b1;
        end else if (!r_wdog_n) begin
            if (r_fire_cnt == 4'hF) begin
                r_wdog_n   <= 1'b1;
                r_fire_cnt <= 4'd0;
                r_wdog_cnt <= '0;
            end else begin
                r_fire_cnt <= r_fire_cnt + 4'd1;
            end
        end else if (w_wr_kick) begin
            r_wdog_cnt <= '0;
        end else if (r_wdog_cnt == c_WW'(WDOG_CYCLES - 1)) begin
            r_wdog_n   <= 1'b0;
            r_fire_cnt <= 4'd0;
        end else begin
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
        end
    end

    assign wdog_reset_n = r_wdog_n;
`else
    assign wdog_reset_n = (WDOG_CYCLES != 0) | 1'b1;
`endif

endmodule
`default_nettype wire
